// File: rtl/lsu_pkg.sv
// Shared types for the load/store execution unit: issue packet layout, CDB
// layout, funct3 codes, FSM states and the access-size decode.
package lsu_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int CDB_W = TAG_W + XLEN;
  localparam int RS_W  = 3 + TAG_W + 3 * XLEN;

  // Tag 0 on the CDB means "no broadcast"; it is never a real destination.
  localparam logic [TAG_W-1:0] TAG_IDLE = '0;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } st_funct3_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_WB    = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    logic [2:0]       funct3;
    logic [TAG_W-1:0] dest;
    logic [XLEN-1:0]  opr1;
    logic [XLEN-1:0]  opr2;
    logic [XLEN-1:0]  offset;
  } rs2exe_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } cdb_t;

  // Unlisted funct3 codes fall back to a full-word access.
  function automatic size_e access_size(input logic [2:0] funct3, input logic store);
    size_e sz;
    sz = SZ_W;
    if (store) begin
      case (funct3)
        SB:      sz = SZ_B;
        SH:      sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (funct3)
        LB, LBU: sz = SZ_B;
        LH, LHU: sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_exec_lane_fmt.sv
// Byte-lane formatting: store byte enables / replicated write data, and
// load lane selection with sign or zero extension.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            store,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] opr2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);

  size_e       size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    size     = access_size(funct3, store);
    // LBU/LHU are the only sub-word codes with bit 2 set.
    uns      = funct3[2];
    byte_sel = rdata[7:0];
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    be    = 4'b1111;
    wdata = opr2;
    ldata = rdata;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{opr2[7:0]}};
        ldata = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{opr2[15:0]}};
        ldata = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be    = 4'b1111;
        wdata = opr2;
        ldata = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_exec.sv
// Load/store execution unit: one memory access at a time via req/ack, result
// broadcast on the CDB. Optional LSU_MISALIGN_CHECK_EN bypasses misaligned ops.
//
// Handshake: mem_req rises in MEM and stays high, with addr/be/wdata stable,
// until the cycle mem_ack is seen high; a kill never drops a pending request.
module lsu_exec
  import lsu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic [RS_W-1:0]  rs2exe,
  input  logic             load_en,
  input  logic             store_en,
  output logic             ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [3:0]       mem_be,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic [CDB_W-1:0] cdb,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic             misalign,
`endif
  output logic [1:0]       dbg_state
);

  rs2exe_t         pkt;
  state_e          state, state_nxt;
  logic            issue;
  logic            issue_mis;
  logic [XLEN-1:0] issue_addr;

  logic [2:0]       funct3_q;
  logic [TAG_W-1:0] dest_q;
  logic [XLEN-1:0]  opr2_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  data_q;
  logic             store_q;

  logic [3:0]      fmt_be;
  logic [XLEN-1:0] fmt_wdata;
  logic [XLEN-1:0] fmt_ldata;
  cdb_t            cdb_w;

  assign pkt        = rs2exe;
  assign issue_addr = pkt.opr1 + pkt.offset;
  // A coincident kill wins over an issue.
  assign issue      = (state == S_IDLE) && (load_en || store_en) && !kill;

`ifdef LSU_MISALIGN_CHECK_EN
  size_e issue_size;
  logic  mis_q;

  assign issue_size = access_size(pkt.funct3, store_en);
  assign issue_mis  = ((issue_size == SZ_H) && issue_addr[0]) ||
                      ((issue_size == SZ_W) && (issue_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (issue) begin
      mis_q <= issue_mis;
    end
  end

  assign misalign = (state == S_WB) && mis_q && !kill;
`else
  assign issue_mis = 1'b0;
`endif

  lsu_lane_fmt u_lane_fmt (
    .funct3 (funct3_q),
    .store  (store_q),
    .off    (addr_q[1:0]),
    .opr2   (opr2_q),
    .rdata  (mem_rdata),
    .be     (fmt_be),
    .wdata  (fmt_wdata),
    .ldata  (fmt_ldata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue) state_nxt = issue_mis ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (mem_ack)   state_nxt = kill ? S_IDLE : S_WB;
        else if (kill) state_nxt = S_DRAIN;
      end
      S_WB:    state_nxt = S_IDLE;
      S_DRAIN: begin
        if (mem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q <= '0;
      dest_q   <= TAG_IDLE;
      opr2_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      store_q  <= 1'b0;
    end else begin
      if (issue) begin
        funct3_q <= pkt.funct3;
        dest_q   <= pkt.dest;
        opr2_q   <= pkt.opr2;
        addr_q   <= issue_addr;
        store_q  <= store_en;
        // A bypassed misaligned op reports its address as the result.
        data_q   <= issue_mis ? issue_addr : '0;
      end
      if ((state == S_MEM) && mem_ack) begin
        data_q <= store_q ? '0 : fmt_ldata;
      end
    end
  end

  always_comb begin
    ready     = (state == S_IDLE);
    mem_req   = (state == S_MEM) || (state == S_DRAIN);
    mem_we    = mem_req && store_q;
    mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    mem_be    = mem_req ? fmt_be : 4'b0000;
    mem_wdata = (mem_req && store_q) ? fmt_wdata : '0;
    cdb_w.tag  = TAG_IDLE;
    cdb_w.data = '0;
    if ((state == S_WB) && !kill) begin
      cdb_w.tag  = dest_q;
      cdb_w.data = data_q;
    end
  end

  assign cdb       = cdb_w;
  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_exec.sv
// Directed self-checking bench for lsu_exec: lane formatting, handshake
// timing, kill/reset behaviour and the misalign option when enabled.
module tb_lsu_exec;

  logic         clk;
  logic         reset;
  logic         kill;
  logic [104:0] rs2exe;
  logic         load_en;
  logic         store_en;
  logic         ready;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic [37:0]  cdb;
  logic [1:0]   dbg_state;
`ifdef LSU_MISALIGN_CHECK_EN
  logic         misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [37:0] exp_q[$];

  lsu_exec dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .rs2exe    (rs2exe),
    .load_en   (load_en),
    .store_en  (store_en),
    .ready     (ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .cdb       (cdb),
`ifdef LSU_MISALIGN_CHECK_EN
    .misalign  (misalign),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one issue for a single cycle, return at the next negedge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [5:0] dest, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] off);
    rs2exe   = {f3, dest, a, b, off};
    load_en  = ld;
    store_en = st;
    @(negedge clk);
    load_en  = 1'b0;
    store_en = 1'b0;
  endtask

  // Full access: issue, hold MEM for 'delay' unacked cycles, ack, check WB.
  task automatic do_access(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [5:0] dest,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] off, input int delay,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data);
    logic [37:0] exp_cdb;
    exp_q.push_back({dest, exp_data});
    issue(ld, st, f3, dest, a, b, off);
    for (int i = 0; i <= delay; i++) begin
      chk({tag, "_req"},   64'(mem_req),   64'h1);
      chk({tag, "_we"},    64'(mem_we),    64'(st));
      chk({tag, "_be"},    64'(mem_be),    64'(exp_be));
      chk({tag, "_addr"},  64'(mem_addr),  64'(exp_addr));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
      chk({tag, "_cdb_busy"}, 64'(cdb),    64'h0);
      if (i == delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    exp_cdb   = exp_q.pop_front();
    chk({tag, "_cdb"},      64'(cdb),     64'(exp_cdb));
    chk({tag, "_wb_req"},   64'(mem_req), 64'h0);
    chk({tag, "_wb_ready"}, 64'(ready),   64'h0);
    @(negedge clk);
    chk({tag, "_cdb_end"},  64'(cdb),     64'h0);
    chk({tag, "_ready"},    64'(ready),   64'h1);
  endtask

  initial begin
    reset     = 1'b1;
    kill      = 1'b0;
    rs2exe    = '0;
    load_en   = 1'b0;
    store_en  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    @(negedge clk);
    chk("rst_state", 64'(dbg_state), 64'h0);
    chk("rst_ready", 64'(ready),     64'h1);
    chk("rst_req",   64'(mem_req),   64'h0);
    chk("rst_cdb",   64'(cdb),       64'h0);
    chk("rst_addr",  64'(mem_addr),  64'h0);
    chk("rst_be",    64'(mem_be),    64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Loads
    do_access("lw",    1, 0, 3'b010, 6'd5,  32'h1000, 32'h0, 32'd4, 0, 32'hDEADBEEF,
              4'b1111, 32'h1004, 32'h0, 32'hDEADBEEF);
    do_access("lb",    1, 0, 3'b000, 6'd7,  32'h2000, 32'h0, 32'd3, 0, 32'h80FFFFFF,
              4'b1000, 32'h2000, 32'h0, 32'hFFFFFF80);
    do_access("lbu",   1, 0, 3'b100, 6'd8,  32'h2000, 32'h0, 32'd3, 0, 32'h80FFFFFF,
              4'b1000, 32'h2000, 32'h0, 32'h00000080);
    do_access("lb1",   1, 0, 3'b000, 6'd16, 32'h5000, 32'h0, 32'd1, 1, 32'h12345678,
              4'b0010, 32'h5000, 32'h0, 32'h00000056);
    do_access("lh",    1, 0, 3'b001, 6'd10, 32'h4000, 32'h0, 32'd2, 0, 32'h80011234,
              4'b1100, 32'h4000, 32'h0, 32'hFFFF8001);
    do_access("lhu",   1, 0, 3'b101, 6'd11, 32'h4000, 32'h0, 32'd2, 0, 32'h80011234,
              4'b1100, 32'h4000, 32'h0, 32'h00008001);
    do_access("lhlo",  1, 0, 3'b001, 6'd17, 32'h4000, 32'h0, 32'd0, 0, 32'h0000F00F,
              4'b0011, 32'h4000, 32'h0, 32'hFFFFF00F);
    do_access("lwrap", 1, 0, 3'b010, 6'd14, 32'hFFFFFFFC, 32'h0, 32'd8, 0, 32'h0BADF00D,
              4'b1111, 32'h00000004, 32'h0, 32'h0BADF00D);
    do_access("ldflt", 1, 0, 3'b110, 6'd15, 32'h8000, 32'h0, 32'd0, 0, 32'h13579BDF,
              4'b1111, 32'h8000, 32'h0, 32'h13579BDF);

    // Stores
    do_access("sh",    0, 1, 3'b001, 6'd9,  32'h3000, 32'h1234ABCD, 32'd2, 4, 32'hFFFFFFFF,
              4'b1100, 32'h3000, 32'hABCDABCD, 32'h0);
    do_access("sb",    0, 1, 3'b000, 6'd12, 32'h6000, 32'hCAFE0077, 32'd1, 1, 32'h0,
              4'b0010, 32'h6000, 32'h77777777, 32'h0);
    do_access("ldst",  1, 1, 3'b010, 6'd13, 32'h7000, 32'h55AA33CC, 32'd8, 0, 32'h0,
              4'b1111, 32'h7008, 32'h55AA33CC, 32'h0);
    do_access("stflt", 0, 1, 3'b111, 6'd18, 32'h7100, 32'h01020304, 32'd0, 0, 32'h0,
              4'b1111, 32'h7100, 32'h01020304, 32'h0);

    // Misaligned accesses
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1, 0, 3'b010, 6'd3, 32'h1000, 32'h0, 32'd2);
    chk("mis_req",   64'(mem_req),  64'h0);
    chk("mis_flag",  64'(misalign), 64'h1);
    chk("mis_cdb",   64'(cdb),      64'({6'd3, 32'h00001002}));
    chk("mis_state", 64'(dbg_state), 64'h2);
    @(negedge clk);
    chk("mis_flag_end", 64'(misalign), 64'h0);
    chk("mis_ready",    64'(ready),    64'h1);
`else
    do_access("lwmis", 1, 0, 3'b010, 6'd3, 32'h1000, 32'h0, 32'd2, 0, 32'h11112222,
              4'b1111, 32'h1000, 32'h0, 32'h11112222);
    do_access("lhodd", 1, 0, 3'b001, 6'd19, 32'h4000, 32'h0, 32'd3, 0, 32'hFEDC0000,
              4'b1100, 32'h4000, 32'h0, 32'hFFFFFEDC);
`endif

    // Kill two cycles into an unacked load, with a load_en in the kill cycle
    issue(1, 0, 3'b010, 6'd20, 32'h9000, 32'h0, 32'd0);
    chk("kd_req0", 64'(mem_req), 64'h1);
    @(negedge clk);
    kill    = 1'b1;
    load_en = 1'b1;
    rs2exe  = {3'b010, 6'd21, 32'hB000, 32'h0, 32'h0};
    @(negedge clk);
    kill    = 1'b0;
    load_en = 1'b0;
    chk("kd_state", 64'(dbg_state), 64'h3);
    chk("kd_req1",  64'(mem_req),   64'h1);
    chk("kd_addr",  64'(mem_addr),  64'h9000);
    chk("kd_ready", 64'(ready),     64'h0);
    chk("kd_cdb1",  64'(cdb),       64'h0);
    @(negedge clk);
    chk("kd_req2",  64'(mem_req),   64'h1);
    chk("kd_cdb2",  64'(cdb),       64'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    mem_ack   = 1'b0;
    chk("kd_done_ready", 64'(ready),   64'h1);
    chk("kd_done_req",   64'(mem_req), 64'h0);
    chk("kd_done_cdb",   64'(cdb),     64'h0);
    @(negedge clk);
    chk("kd_idle_req",   64'(mem_req), 64'h0);
    chk("kd_idle_cdb",   64'(cdb),     64'h0);

    // Kill coincident with issue in IDLE
    rs2exe  = {3'b010, 6'd25, 32'hC000, 32'h0, 32'h0};
    load_en = 1'b1;
    kill    = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    kill    = 1'b0;
    chk("ki_ready", 64'(ready),     64'h1);
    chk("ki_req",   64'(mem_req),   64'h0);
    chk("ki_state", 64'(dbg_state), 64'h0);

    // Kill in MEM with a same-cycle ack
    issue(1, 0, 3'b010, 6'd21, 32'hC100, 32'h0, 32'd0);
    kill      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77778888;
    @(negedge clk);
    kill      = 1'b0;
    mem_ack   = 1'b0;
    chk("ka_ready", 64'(ready), 64'h1);
    chk("ka_cdb",   64'(cdb),   64'h0);
    chk("ka_req",   64'(mem_req), 64'h0);

    // Kill in WB suppresses the broadcast
    issue(1, 0, 3'b010, 6'd22, 32'hC200, 32'h0, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h99990000;
    @(negedge clk);
    mem_ack   = 1'b0;
    chk("kw_state", 64'(dbg_state), 64'h2);
    kill = 1'b1;
    #1;
    chk("kw_cdb", 64'(cdb), 64'h0);
    @(negedge clk);
    kill = 1'b0;
    chk("kw_ready", 64'(ready), 64'h1);
    chk("kw_cdb_end", 64'(cdb), 64'h0);

    // Issue while busy is dropped; async reset mid-MEM abandons the request
    issue(1, 0, 3'b010, 6'd23, 32'hA000, 32'h0, 32'd0);
    load_en = 1'b1;
    rs2exe  = {3'b010, 6'd24, 32'hB000, 32'h0, 32'h0};
    @(negedge clk);
    load_en = 1'b0;
    chk("rb_addr",  64'(mem_addr),  64'hA000);
    chk("rb_state", 64'(dbg_state), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ra_req",   64'(mem_req),   64'h0);
    chk("ra_cdb",   64'(cdb),       64'h0);
    chk("ra_state", 64'(dbg_state), 64'h0);
    chk("ra_ready", 64'(ready),     64'h1);
    chk("ra_addr",  64'(mem_addr),  64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ra_post_req", 64'(mem_req), 64'h0);
    do_access("post", 1, 0, 3'b010, 6'd26, 32'hD000, 32'h0, 32'd12, 2, 32'h2468ACE0,
              4'b1111, 32'hD00C, 32'h0, 32'h2468ACE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
